// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage: slot payloads, difftest record,
// FSM state and the selected-exception bundle.
package wb_commit_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int EXC_VEC_W   = 6;
    localparam int ECODE_W     = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXCP_PEND = 2'd1,
        FLUSH     = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [EXC_VEC_W-1:0]              excp_vec;
        logic [EXC_VEC_W-1:0][ECODE_W-1:0] excp_code;
        logic [31:0]                       pc;
        logic [31:0]                       inst;
        logic [31:0]                       mem_addr;
        logic [7:0]                        aluop;
        logic                              is_privilege;
    } commit_ctrl_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        csr_write_en;
        logic [13:0] csr_waddr;
        logic [31:0] csr_wdata;
    } mem_wb_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic [31:0]        inst;
        logic               rf_wen;
        logic [4:0]         rf_wdest;
        logic [31:0]        rf_wdata;
        logic               excp_flush;
        logic [ECODE_W-1:0] ecode;
    } diff_t;

    typedef struct packed {
        logic [ECODE_W-1:0] ecode;
        logic [31:0]        badv;
        logic [31:0]        pc;
        logic               slot;
    } excp_sel_t;

endpackage

// File: rtl/excp_prio_sel.sv
// Per-slot exception priority encoder: highest set flag wins; bit 0 (data
// TLB/ALE) reports the memory address as badv, every other flag the pc.
module excp_prio_sel
    import wb_commit_pkg::*;
#(
    parameter bit SLOT = 1'b0
) (
    input  logic                              valid,
    input  logic [EXC_VEC_W-1:0]              excp_vec,
    input  logic [EXC_VEC_W-1:0][ECODE_W-1:0] excp_code,
    input  logic [31:0]                       pc,
    input  logic [31:0]                       mem_addr,
    output logic                              fault,
    output excp_sel_t                         sel
);

    always_comb begin
        sel      = '0;
        sel.pc   = pc;
        sel.slot = SLOT;
        sel.badv = pc;
        fault    = valid && (excp_vec != '0);
        // Ascending scan so the highest set bit is the last one written.
        for (int unsigned i = 0; i < EXC_VEC_W; i++) begin
            if (excp_vec[i]) begin
                sel.ecode = excp_code[i];
                sel.badv  = (i == 0) ? mem_addr : pc;
            end
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage with precise-exception commit and req/ack handshake.
// Optional difftest output diff_o is enabled with `define WB_DIFF_EN.
module wb_commit
    import wb_commit_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic [ISSUE_WIDTH-1:0]             valid_i,
    input  commit_ctrl_t [ISSUE_WIDTH-1:0]     commit_ctrl_i,
    input  mem_wb_t [ISSUE_WIDTH-1:0]          wb_i,
    input  logic                               excp_ack_i,
    output logic [ISSUE_WIDTH-1:0]             reg_we_o,
    output logic [ISSUE_WIDTH-1:0][4:0]        reg_waddr_o,
    output logic [ISSUE_WIDTH-1:0][31:0]       reg_wdata_o,
    output logic                               csr_we_o,
    output logic [13:0]                        csr_waddr_o,
    output logic [31:0]                        csr_wdata_o,
    output logic                               excp_req_o,
    output logic [ECODE_W-1:0]                 excp_ecode_o,
    output logic [31:0]                        excp_pc_o,
    output logic [31:0]                        excp_badv_o,
    output logic                               excp_slot_o,
    output logic                               pause_wb_o
`ifdef WB_DIFF_EN
    ,
    output diff_t [ISSUE_WIDTH-1:0]            diff_o
`endif
);

    wb_state_t                      state_q, state_d;
    logic [ISSUE_WIDTH-1:0]         valid_q;
    commit_ctrl_t [ISSUE_WIDTH-1:0] ctrl_q;
    mem_wb_t [ISSUE_WIDTH-1:0]      wb_q;
    excp_sel_t                      sel_q;

    logic [ISSUE_WIDTH-1:0]         fault;
    excp_sel_t                      sel [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]         commit;
    logic                           exc_hit;
    excp_sel_t                      exc_cur;
    logic                           ctrl_unused;

    assign ctrl_unused = ^{ctrl_q[0].inst, ctrl_q[0].aluop, ctrl_q[0].is_privilege,
                           ctrl_q[1].inst, ctrl_q[1].aluop, ctrl_q[1].is_privilege};

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_prio
        excp_prio_sel #(.SLOT(1'(g))) u_sel (
            .valid     (valid_q[g]),
            .excp_vec  (ctrl_q[g].excp_vec),
            .excp_code (ctrl_q[g].excp_code),
            .pc        (ctrl_q[g].pc),
            .mem_addr  (ctrl_q[g].mem_addr),
            .fault     (fault[g]),
            .sel       (sel[g])
        );
    end

    // Commit rules: an older fault blocks everything; a younger fault only blocks itself.
    always_comb begin
        commit      = '0;
        exc_hit     = 1'b0;
        exc_cur     = '0;
        reg_we_o    = '0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        if (state_q == IDLE) begin
            if (fault[0]) begin
                exc_hit = 1'b1;
                exc_cur = sel[0];
            end else begin
                commit[0] = valid_q[0];
                if (fault[1]) begin
                    exc_hit = 1'b1;
                    exc_cur = sel[1];
                end else begin
                    commit[1] = valid_q[1];
                end
            end
        end
        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            reg_we_o[s] = commit[s] && wb_q[s].reg_we && (wb_q[s].reg_waddr != '0);
        end
        if (reg_we_o[0] && reg_we_o[1] && (wb_q[0].reg_waddr == wb_q[1].reg_waddr)) begin
            reg_we_o[0] = 1'b0;
        end
        if (commit[0] && wb_q[0].csr_write_en) begin
            csr_we_o    = 1'b1;
            csr_waddr_o = wb_q[0].csr_waddr;
            csr_wdata_o = wb_q[0].csr_wdata;
        end else if (commit[1] && wb_q[1].csr_write_en) begin
            csr_we_o    = 1'b1;
            csr_waddr_o = wb_q[1].csr_waddr;
            csr_wdata_o = wb_q[1].csr_wdata;
        end
    end

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_rf
        assign reg_waddr_o[g] = wb_q[g].reg_waddr;
        assign reg_wdata_o[g] = wb_q[g].reg_wdata;
    end

    always_comb begin
        state_d      = state_q;
        excp_req_o   = 1'b0;
        excp_ecode_o = '0;
        excp_pc_o    = '0;
        excp_badv_o  = '0;
        excp_slot_o  = 1'b0;
        pause_wb_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exc_hit) begin
                    excp_req_o   = 1'b1;
                    excp_ecode_o = exc_cur.ecode;
                    excp_pc_o    = exc_cur.pc;
                    excp_badv_o  = exc_cur.badv;
                    excp_slot_o  = exc_cur.slot;
                    pause_wb_o   = 1'b1;
                    state_d      = EXCP_PEND;
                end
            end
            EXCP_PEND: begin
                excp_req_o   = 1'b1;
                excp_ecode_o = sel_q.ecode;
                excp_pc_o    = sel_q.pc;
                excp_badv_o  = sel_q.badv;
                excp_slot_o  = sel_q.slot;
                pause_wb_o   = 1'b1;
                if (excp_ack_i) state_d = FLUSH;
            end
            FLUSH: begin
                pause_wb_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // The payload is captured at detection so it stays stable while req is held,
    // even though the stage register may reload in that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            ctrl_q  <= '0;
            wb_q    <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && exc_hit && !flush_i) begin
                sel_q <= exc_cur;
            end
            if (flush_i || (state_q == FLUSH)) begin
                valid_q <= '0;
            end else if ((state_q == IDLE) && !stall_i) begin
                valid_q <= valid_i;
                ctrl_q  <= commit_ctrl_i;
                wb_q    <= wb_i;
            end
        end
    end

`ifdef WB_DIFF_EN
    diff_t [ISSUE_WIDTH-1:0] diff_d;

    always_comb begin
        diff_d = '0;
        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            diff_d[s].excp_flush = exc_hit && (exc_cur.slot == 1'(s));
            diff_d[s].valid      = commit[s] || diff_d[s].excp_flush;
            diff_d[s].pc         = ctrl_q[s].pc;
            diff_d[s].inst       = ctrl_q[s].inst;
            diff_d[s].rf_wen     = reg_we_o[s];
            diff_d[s].rf_wdest   = reg_we_o[s] ? wb_q[s].reg_waddr : '0;
            diff_d[s].rf_wdata   = reg_we_o[s] ? wb_q[s].reg_wdata : '0;
            diff_d[s].ecode      = diff_d[s].excp_flush ? exc_cur.ecode : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            diff_o <= '0;
        end else begin
            diff_o <= diff_d;
        end
    end
`endif

endmodule
